// File: rtl/dma_timing_control.sv
// dma_timing_control
// Timing and control stage of an 8237-style DMA controller. Arbitrates the
// channel requests, runs the HRQ/HLDA hold handshake and sequences one
// single-mode bus cycle through states SI, S0..S4.
//
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   DREQ[NUM_CH]            per-channel requests
//   HLDA                    hold acknowledge from the CPU
//   CS_N                    CPU chip select (programming access blocks new requests)
//   maskReg, modeXfer,
//   ctrlDisable             register fields (mask, transfer type, command bit 2)
//   tcReached               datapath: this transfer is the last one
//   HRQ, AEN, ADSTB         bus handshake / address enable / upper address strobe
//   MEMR_N, MEMW_N,
//   IOR_N_OUT, IOW_N_OUT    active-low transfer strobes
//   DACK, EOP_N             one-hot acknowledge, end of process
//   loadAddr, programCondition,
//   updateAddr              datapath controls
//   activeCh, tcSet         channel in service, status TC set pulse
//
// Build option: define ROTATING_PRIORITY_EN for rotating priority; otherwise
// fixed priority with channel 0 highest.

module dma_timing_control #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NUM_CH-1:0]   DREQ,
    input  logic                HLDA,
    input  logic                CS_N,
    input  logic [NUM_CH-1:0]   maskReg,
    input  logic [2*NUM_CH-1:0] modeXfer,
    input  logic                ctrlDisable,
    input  logic                tcReached,
    output logic                HRQ,
    output logic                AEN,
    output logic                ADSTB,
    output logic                MEMR_N,
    output logic                MEMW_N,
    output logic                IOR_N_OUT,
    output logic                IOW_N_OUT,
    output logic [NUM_CH-1:0]   DACK,
    output logic                EOP_N,
    output logic                loadAddr,
    output logic                programCondition,
    output logic                updateAddr,
    output logic [CH_W-1:0]     activeCh,
    output logic [NUM_CH-1:0]   tcSet
);

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_S4 = 3'd5
    } state_t;

    localparam logic [1:0] MODE_WRITE = 2'b01;  // IO -> memory
    localparam logic [1:0] MODE_READ  = 2'b10;  // memory -> IO

    state_t              state, state_nxt;
    logic [NUM_CH-1:0]   req;
    logic [CH_W-1:0]     grant_ch;
    logic [1:0]          mode_act;
    logic [NUM_CH-1:0]   ch_onehot;

    assign req       = DREQ & ~maskReg & {NUM_CH{~ctrlDisable}};
    assign mode_act  = modeXfer[{activeCh, 1'b0} +: 2];
    assign ch_onehot = NUM_CH'(1) << activeCh;

    // ------------------------------------------------------------------
    // Arbitration. Loops run from lowest to highest priority so the last
    // hit (the highest-priority requester) wins.
    // ------------------------------------------------------------------
`ifdef ROTATING_PRIORITY_EN
    logic [CH_W-1:0] prio_ptr;  // channel currently holding highest priority

    always_comb begin
        grant_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[(int'(prio_ptr) + k) % NUM_CH])
                grant_ch = CH_W'((int'(prio_ptr) + k) % NUM_CH);
        end
    end

    // A channel that completes S4 drops to lowest priority.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            prio_ptr <= '0;
        else if (state == ST_S4)
            prio_ptr <= CH_W'((int'(activeCh) + 1) % NUM_CH);
    end
`else
    always_comb begin
        grant_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k])
                grant_ch = CH_W'(k);
        end
    end
`endif

    // ------------------------------------------------------------------
    // State and channel registers
    // ------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_SI;
            activeCh <= '0;
        end else begin
            state <= state_nxt;
            // Winner is frozen for the whole bus cycle.
            if (state == ST_SI && state_nxt == ST_S0)
                activeCh <= grant_ch;
        end
    end

    // ------------------------------------------------------------------
    // Next state. Losing HLDA in S1..S3 aborts without an address update.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path through the case leaves
        // state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        unique case (state)
            ST_SI: if ((|req) && CS_N) state_nxt = ST_S0;
            ST_S0: begin
                if (HLDA)                state_nxt = ST_S1;
                else if (!DREQ[activeCh]) state_nxt = ST_SI;
            end
            ST_S1:   state_nxt = HLDA ? ST_S2 : ST_SI;
            ST_S2:   state_nxt = HLDA ? ST_S3 : ST_SI;
            ST_S3:   state_nxt = HLDA ? ST_S4 : ST_SI;
            ST_S4:   state_nxt = ST_SI;
            default: state_nxt = ST_SI;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register (Moore), so an async reset
    // releases every strobe immediately.
    // ------------------------------------------------------------------
    always_comb begin
        HRQ              = (state != ST_SI);
        AEN              = 1'b0;
        ADSTB            = 1'b0;
        loadAddr         = 1'b0;
        updateAddr       = 1'b0;
        MEMR_N           = 1'b1;
        MEMW_N           = 1'b1;
        IOR_N_OUT        = 1'b1;
        IOW_N_OUT        = 1'b1;
        DACK             = '0;
        EOP_N            = 1'b1;
        tcSet            = '0;
        programCondition = (state == ST_SI) && !CS_N;

        unique case (state)
            ST_S1: begin
                AEN      = 1'b1;
                ADSTB    = 1'b1;
                loadAddr = 1'b1;
                DACK     = ch_onehot;
            end
            ST_S2, ST_S3: begin
                AEN  = 1'b1;
                DACK = ch_onehot;
                if (mode_act == MODE_READ) begin
                    MEMR_N    = 1'b0;
                    IOW_N_OUT = 1'b0;
                end else if (mode_act == MODE_WRITE) begin
                    IOR_N_OUT = 1'b0;
                    MEMW_N    = 1'b0;
                end
            end
            ST_S4: begin
                AEN        = 1'b1;
                DACK       = ch_onehot;
                updateAddr = 1'b1;
                if (tcReached) begin
                    EOP_N = 1'b0;
                    tcSet = ch_onehot;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_timing_control.sv
module tb_dma_timing_control;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                CLK = 1'b0;
    logic                RESET_N;
    logic [NUM_CH-1:0]   DREQ;
    logic                HLDA;
    logic                CS_N;
    logic [NUM_CH-1:0]   maskReg;
    logic [2*NUM_CH-1:0] modeXfer;
    logic                ctrlDisable;
    logic                tcReached;
    logic                HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT;
    logic [NUM_CH-1:0]   DACK;
    logic                EOP_N, loadAddr, programCondition, updateAddr;
    logic [CH_W-1:0]     activeCh;
    logic [NUM_CH-1:0]   tcSet;

    dma_timing_control #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .CS_N(CS_N),
        .maskReg(maskReg), .modeXfer(modeXfer), .ctrlDisable(ctrlDisable),
        .tcReached(tcReached), .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N_OUT(IOR_N_OUT),
        .IOW_N_OUT(IOW_N_OUT), .DACK(DACK), .EOP_N(EOP_N), .loadAddr(loadAddr),
        .programCondition(programCondition), .updateAddr(updateAddr),
        .activeCh(activeCh), .tcSet(tcSet)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         ch;
        logic [1:0] mode;
        bit         tc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // CPU model controls
    bit hlda_en    = 1'b1;
    bit hlda_kill  = 1'b0;
    int hlda_delay = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic [1:0] mode, input bit tc);
        exp_t e;
        e.ch = ch; e.mode = mode; e.tc = tc;
        q.push_back(e);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return HRQ;
            1:       return AEN;
            default: return updateAddr;
        endcase
    endfunction

    // Bounded wait: 0 = HRQ, 1 = AEN, 2 = updateAddr
    task automatic wait_until(input int which, input string name);
        for (int i = 0; i < 50; i++) begin
            if (sig(which)) return;
            cyc();
        end
        total++;
        bad++;
        $display("FAIL timeout_%s: got 0 expected 1", name);
    endtask

    function automatic logic [3:0] exp_strobes(input logic [1:0] mode);
        // {MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT}
        case (mode)
            2'b10:   return 4'b0110;
            2'b01:   return 4'b1001;
            default: return 4'b1111;
        endcase
    endfunction

    // CPU hold responder: grants HLDA hlda_delay cycles after HRQ, releases with HRQ.
    initial begin
        int wait_cnt = 0;
        HLDA = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (HRQ && hlda_en && !hlda_kill) begin
                if (wait_cnt >= hlda_delay) HLDA = 1'b1;
                else wait_cnt++;
            end else begin
                HLDA     = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every updateAddr pulse is a completed transfer; compare with queue.
    initial begin
        logic [3:0] last_str = 4'hF;
        exp_t       e;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                last_str = 4'hF;
            end else begin
                if (AEN && !ADSTB && !updateAddr)
                    last_str = {MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT};
                if (updateAddr) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_xfer: got ch %0d expected none", activeCh);
                    end else begin
                        e = q.pop_front();
                        check("xfer_ch", 32'(activeCh), 32'(e.ch));
                        check("xfer_dack", 32'(DACK), 32'(1 << e.ch));
                        check("xfer_eop_n", 32'(EOP_N), 32'(!e.tc));
                        check("xfer_tcset", 32'(tcSet), e.tc ? 32'(1 << e.ch) : 32'd0);
                        check("xfer_strobes", 32'(last_str), 32'(exp_strobes(e.mode)));
                        check("s4_strobes_idle", 32'({MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT}), 32'hF);
                    end
                    last_str = 4'hF;
                end
            end
        end
    end

    initial begin
        RESET_N     = 1'b0;
        DREQ        = '0;
        CS_N        = 1'b1;
        maskReg     = '0;
        // ch3 read, ch2 read, ch1 write, ch0 verify
        modeXfer    = 8'b10_10_01_00;
        ctrlDisable = 1'b0;
        tcReached   = 1'b0;
        repeat (3) cyc();
        RESET_N = 1'b1;
        #1;

        // ---- Reset state ----
        check("rst_hrq", HRQ, 0);
        check("rst_aen", AEN, 0);
        check("rst_dack", DACK, 0);
        check("rst_strobes", {MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT}, 4'hF);
        check("rst_eop_n", EOP_N, 1);
        check("rst_tcset", tcSet, 0);
        check("rst_active", activeCh, 0);
        check("rst_update", updateAddr, 0);
        check("rst_progcond", programCondition, 0);

        // ---- Priority: ch1 beats ch3, then ch3 ----
        push_exp(1, 2'b01, 0);
        push_exp(3, 2'b10, 0);
        DREQ = 4'b1010;
        wait_until(2, "prio_ch1");
        DREQ = 4'b1000;
        cyc();
        wait_until(2, "prio_ch3");
        DREQ = 4'b0000;
        cyc();

        // ---- Mask: ch1 masked, ch3 only ----
        maskReg = 4'b0010;
        push_exp(3, 2'b10, 0);
        DREQ = 4'b1010;
        wait_until(2, "mask_ch3");
        DREQ    = 4'b0000;
        cyc();
        maskReg = 4'b0000;

        // ---- ctrlDisable blocks all requests ----
        ctrlDisable = 1'b1;
        DREQ        = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("disabled_hrq", HRQ, 0);
        end
        DREQ        = 4'b0000;
        ctrlDisable = 1'b0;
        cyc();

        // ---- Read transfer ch2, HLDA two cycles after HRQ ----
        hlda_delay = 2;
        push_exp(2, 2'b10, 0);
        DREQ = 4'b0100;
        wait_until(1, "read_s1");
        check("read_s1_dack", DACK, 4'b0100);
        check("read_s1_adstb", ADSTB, 1);
        check("read_s1_loadaddr", loadAddr, 1);
        cyc();
        check("read_s2_adstb", ADSTB, 0);
        check("read_s2_memr", MEMR_N, 0);
        check("read_s2_iow", IOW_N_OUT, 0);
        check("read_s2_memw", MEMW_N, 1);
        cyc();
        check("read_s3_memr", MEMR_N, 0);
        check("read_s3_iow", IOW_N_OUT, 0);
        cyc();
        check("read_s4_update", updateAddr, 1);
        DREQ = 4'b0000;
        cyc();
        check("read_done_hrq", HRQ, 0);
        check("read_done_dack", DACK, 0);
        check("read_done_update", updateAddr, 0);
        hlda_delay = 1;

        // ---- Terminal count on ch1 write ----
        tcReached = 1'b1;
        push_exp(1, 2'b01, 1);
        DREQ = 4'b0010;
        wait_until(2, "tc_s4");
        DREQ = 4'b0000;
        cyc();
        check("tc_pulse_end", tcSet, 0);
        check("tc_eop_end", EOP_N, 1);
        tcReached = 1'b0;

        // ---- CPU access blocks request ----
        CS_N = 1'b0;
        DREQ = 4'b0001;
        #1;
        check("cpu_progcond", programCondition, 1);
        cyc();
        check("cpu_hrq_blocked", HRQ, 0);
        cyc();
        check("cpu_hrq_blocked2", HRQ, 0);
        push_exp(0, 2'b00, 0);
        CS_N = 1'b1;
        #1;
        check("cpu_progcond_off", programCondition, 0);
        cyc();
        check("cpu_hrq_next", HRQ, 1);
        check("s0_progcond", programCondition, 0);
        wait_until(2, "cpu_verify");
        DREQ = 4'b0000;
        cyc();

        // ---- DREQ withdrawn in S0 ----
        hlda_en = 1'b0;
        DREQ    = 4'b0001;
        cyc();
        check("s0_hrq", HRQ, 1);
        DREQ = 4'b0000;
        cyc();
        check("s0_drop_hrq", HRQ, 0);
        hlda_en = 1'b1;

        // ---- HLDA dropped in S2: abort ----
        DREQ = 4'b0100;
        wait_until(1, "abort_s1");
        @(negedge CLK);
        hlda_kill = 1'b1;
        cyc();
        DREQ = 4'b0000;
        check("abort_s2_aen", AEN, 1);
        cyc();
        check("abort_hrq", HRQ, 0);
        check("abort_aen", AEN, 0);
        check("abort_memr", MEMR_N, 1);
        check("abort_update", updateAddr, 0);
        hlda_kill = 1'b0;
        cyc();

        // ---- Async reset in the middle of S2 ----
        DREQ = 4'b0100;
        wait_until(1, "rst_s1");
        cyc();
        check("pre_rst_memr", MEMR_N, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("midrst_hrq", HRQ, 0);
        check("midrst_memr", MEMR_N, 1);
        check("midrst_dack", DACK, 0);
        check("midrst_eop", EOP_N, 1);
        DREQ = 4'b0000;
        cyc();
        RESET_N = 1'b1;
        cyc();

        // ---- Two requesters held: priority order ----
`ifdef ROTATING_PRIORITY_EN
        push_exp(0, 2'b00, 0); push_exp(1, 2'b01, 0);
        push_exp(0, 2'b00, 0); push_exp(1, 2'b01, 0);
`else
        push_exp(0, 2'b00, 0); push_exp(0, 2'b00, 0);
        push_exp(0, 2'b00, 0); push_exp(0, 2'b00, 0);
`endif
        DREQ = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            wait_until(2, "order");
            if (i == 3) DREQ = 4'b0000;
            cyc();
        end

        repeat (4) cyc();
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
